// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the external-memory Wishbone arbiter.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_ABORT  = 2'd2
  } arb_state_e;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam int TMO_CNT_W = 16;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester above last_grant, else lowest requester.
module rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter  int NUM_MASTERS = 3,
  localparam int IDX_W       = idx_width(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]       last_grant,
  output logic [NUM_MASTERS-1:0] grant
);

  logic [NUM_MASTERS-1:0] hi_mask;
  logic [NUM_MASTERS-1:0] req_hi;
  logic [NUM_MASTERS-1:0] pick_hi;
  logic [NUM_MASTERS-1:0] pick_lo;

  always_comb begin
    hi_mask = '0;
    for (int j = 0; j < NUM_MASTERS; j++) begin
      hi_mask[j] = (j > int'(last_grant));
    end
  end

  // x & -x isolates the lowest set bit
  assign req_hi  = req & hi_mask;
  assign pick_hi = req_hi & (~req_hi + NUM_MASTERS'(1));
  assign pick_lo = req & (~req + NUM_MASTERS'(1));
  assign grant   = (|req_hi) ? pick_hi : pick_lo;

endmodule

// File: rtl/wb_ext_mem_arbiter.sv
// Round-robin Wishbone arbiter giving NUM_MASTERS masters access to one external
// memory slave, with whole-cycle ownership and a stalled-strobe timeout abort.
module wb_ext_mem_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = 3,
  parameter int MEM_ADDR_WIDTH = 27,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                                  clk,
  input  logic                                  rst_sys_n,
  input  logic [NUM_MASTERS*MEM_ADDR_WIDTH-1:0] m_adr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]     m_dat_i,
  input  logic [NUM_MASTERS*(DATA_WIDTH/8)-1:0] m_sel_i,
  input  logic [NUM_MASTERS-1:0]                m_we_i,
  input  logic [NUM_MASTERS-1:0]                m_cyc_i,
  input  logic [NUM_MASTERS-1:0]                m_stb_i,
  input  logic [NUM_MASTERS*3-1:0]              m_cti_i,
  input  logic [NUM_MASTERS*2-1:0]              m_bte_i,
  output logic [NUM_MASTERS*DATA_WIDTH-1:0]     m_dat_o,
  output logic [NUM_MASTERS-1:0]                m_ack_o,
  output logic [NUM_MASTERS-1:0]                m_err_o,
  output logic [NUM_MASTERS-1:0]                m_rty_o,
  output logic [MEM_ADDR_WIDTH-1:0]             s_adr_o,
  output logic [DATA_WIDTH-1:0]                 s_dat_o,
  output logic [DATA_WIDTH/8-1:0]               s_sel_o,
  output logic                                  s_we_o,
  output logic                                  s_cyc_o,
  output logic                                  s_stb_o,
  output logic [2:0]                            s_cti_o,
  output logic [1:0]                            s_bte_o,
  input  logic [DATA_WIDTH-1:0]                 s_dat_i,
  input  logic                                  s_ack_i,
  input  logic                                  s_err_i,
  input  logic                                  s_rty_i,
  output logic [NUM_MASTERS-1:0]                grant_o,
  output logic [TMO_CNT_W-1:0]                  timeout_cnt_o
);

  localparam int SEL_W = DATA_WIDTH / 8;
  localparam int IDX_W = idx_width(NUM_MASTERS);
  // Abort fires when this many strobe cycles have already gone unanswered
  localparam logic [TMO_CNT_W-1:0] STALL_LIMIT = TMO_CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_e             state_q, state_d;
  logic [IDX_W-1:0]       last_grant_q;
  logic [TMO_CNT_W-1:0]   stall_cnt_q;
  logic [TMO_CNT_W-1:0]   timeout_cnt_q;
  logic                   armed_q;
  logic [NUM_MASTERS-1:0] req;
  logic [NUM_MASTERS-1:0] rr_grant;
  logic [IDX_W-1:0]       rr_idx;
  logic                   owned;
  logic                   s_resp;

  logic [MEM_ADDR_WIDTH-1:0] own_adr;
  logic [DATA_WIDTH-1:0]     own_dat;
  logic [SEL_W-1:0]          own_sel;
  logic                      own_we, own_cyc, own_stb;
  logic [2:0]                own_cti;
  logic [1:0]                own_bte;

  assign req    = m_cyc_i & m_stb_i;
  assign owned  = (state_q != ST_IDLE);
  assign s_resp = s_ack_i | s_err_i | s_rty_i;

  rr_arbiter #(.NUM_MASTERS(NUM_MASTERS)) u_rr (
    .req        (req),
    .last_grant (last_grant_q),
    .grant      (rr_grant)
  );

  always_comb begin
    rr_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (rr_grant[i]) rr_idx = IDX_W'(i);
    end
  end

  // last_grant only moves on a grant, so it names the owner whenever not idle
  always_comb begin
    own_adr = '0;
    own_dat = '0;
    own_sel = '0;
    own_we  = 1'b0;
    own_cyc = 1'b0;
    own_stb = 1'b0;
    own_cti = '0;
    own_bte = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (owned && int'(last_grant_q) == i) begin
        own_adr = m_adr_i[i*MEM_ADDR_WIDTH +: MEM_ADDR_WIDTH];
        own_dat = m_dat_i[i*DATA_WIDTH +: DATA_WIDTH];
        own_sel = m_sel_i[i*SEL_W +: SEL_W];
        own_we  = m_we_i[i];
        own_cyc = m_cyc_i[i];
        own_stb = m_stb_i[i];
        own_cti = m_cti_i[i*3 +: 3];
        own_bte = m_bte_i[i*2 +: 2];
      end
    end
  end

  assign s_adr_o = own_adr;
  assign s_dat_o = own_dat;
  assign s_sel_o = own_sel;
  assign s_we_o  = own_we;
  assign s_cti_o = own_cti;
  assign s_bte_o = own_bte;
  assign s_cyc_o = (state_q == ST_ACTIVE) && own_cyc;
  assign s_stb_o = (state_q == ST_ACTIVE) && own_stb;

  always_comb begin
    m_dat_o = '0;
    m_ack_o = '0;
    m_err_o = '0;
    m_rty_o = '0;
    grant_o = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (owned && int'(last_grant_q) == i) begin
        grant_o[i] = 1'b1;
        if (state_q == ST_ACTIVE) begin
          m_dat_o[i*DATA_WIDTH +: DATA_WIDTH] = s_dat_i;
          m_ack_o[i] = s_ack_i;
          m_err_o[i] = s_err_i;
          m_rty_o[i] = s_rty_i;
        end else begin
          m_err_o[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (armed_q && (|req)) state_d = ST_ACTIVE;
      ST_ACTIVE: begin
        if (!own_cyc) state_d = ST_IDLE;
        else if (own_stb && !s_resp && stall_cnt_q == STALL_LIMIT) state_d = ST_ABORT;
      end
      ST_ABORT:  state_d = own_cyc ? ST_ACTIVE : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // armed_q holds off arbitration for the first edge after reset release
  always_ff @(posedge clk or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      state_q       <= ST_IDLE;
      last_grant_q  <= IDX_W'(NUM_MASTERS - 1);
      stall_cnt_q   <= '0;
      timeout_cnt_q <= '0;
      armed_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= 1'b1;
      if (state_q == ST_IDLE && state_d == ST_ACTIVE) last_grant_q <= rr_idx;
      if (state_q != ST_ACTIVE || s_resp) stall_cnt_q <= '0;
      else if (own_stb) stall_cnt_q <= stall_cnt_q + TMO_CNT_W'(1);
      if (state_q == ST_ABORT && timeout_cnt_q != '1)
        timeout_cnt_q <= timeout_cnt_q + TMO_CNT_W'(1);
    end
  end

  assign timeout_cnt_o = timeout_cnt_q;

endmodule

// File: tb/tb_wb_ext_mem_arbiter.sv
// Directed bench for wb_ext_mem_arbiter: three masters, TIMEOUT_CYCLES=4.
module tb_wb_ext_mem_arbiter;
  import wb_arb_pkg::*;

  localparam int NM = 3;
  localparam int AW = 27;
  localparam int DW = 32;
  localparam int SW = 4;

  logic clk = 1'b0;
  logic rst_sys_n;

  logic [NM-1:0][AW-1:0] m_adr;
  logic [NM-1:0][DW-1:0] m_dat_w;
  logic [NM-1:0][SW-1:0] m_sel;
  logic [NM-1:0]         m_we, m_cyc, m_stb;
  logic [NM-1:0][2:0]    m_cti;
  logic [NM-1:0][1:0]    m_bte;
  logic [NM-1:0][DW-1:0] m_dat_r;
  logic [NM-1:0]         m_ack, m_err, m_rty;

  logic [AW-1:0] s_adr;
  logic [DW-1:0] s_dat_w, s_dat_r;
  logic [SW-1:0] s_sel;
  logic          s_we, s_cyc, s_stb;
  logic [2:0]    s_cti;
  logic [1:0]    s_bte;
  logic          s_ack, s_err, s_rty;
  logic [NM-1:0] grant;
  logic [15:0]   timeout_cnt;

  logic auto_ack, ack_force;
  int   n_pass, n_total;

  always #5 clk = ~clk;

  assign s_ack = ack_force | (auto_ack & s_cyc & s_stb);

  wb_ext_mem_arbiter #(
    .NUM_MASTERS(NM), .MEM_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk), .rst_sys_n(rst_sys_n),
    .m_adr_i(m_adr), .m_dat_i(m_dat_w), .m_sel_i(m_sel), .m_we_i(m_we),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_cti_i(m_cti), .m_bte_i(m_bte),
    .m_dat_o(m_dat_r), .m_ack_o(m_ack), .m_err_o(m_err), .m_rty_o(m_rty),
    .s_adr_o(s_adr), .s_dat_o(s_dat_w), .s_sel_o(s_sel), .s_we_o(s_we),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_cti_o(s_cti), .s_bte_o(s_bte),
    .s_dat_i(s_dat_r), .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty),
    .grant_o(grant), .timeout_cnt_o(timeout_cnt)
  );

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_masters();
    m_adr = '0; m_dat_w = '0; m_sel = '0; m_we = '0;
    m_cyc = '0; m_stb = '0; m_cti = '0; m_bte = '0;
  endtask

  task automatic apply_reset();
    rst_sys_n = 1'b0;
    clear_masters();
    auto_ack = 1'b0;
    ack_force = 1'b0;
    cycle();
    cycle();
    rst_sys_n = 1'b1;
    cycle();
  endtask

  task automatic test_reset();
    rst_sys_n = 1'b0;
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    cycle();
    cycle();
    n_total++; if (grant !== 3'b000) $display("FAIL rst_grant: got %b expected 000", grant); else n_pass++;
    n_total++; if (s_cyc !== 1'b0 || s_stb !== 1'b0) $display("FAIL rst_s_cyc_stb: got %b%b expected 00", s_cyc, s_stb); else n_pass++;
    n_total++; if ((m_ack | m_err | m_rty) !== 3'b000) $display("FAIL rst_resp: got %b expected 000", m_ack | m_err | m_rty); else n_pass++;
    n_total++; if (timeout_cnt !== 16'd0) $display("FAIL rst_timeout_cnt: got %0d expected 0", timeout_cnt); else n_pass++;
    rst_sys_n = 1'b1;
    cycle();
    n_total++; if (grant !== 3'b000) $display("FAIL rst_first_edge_grant: got %b expected 000", grant); else n_pass++;
    cycle();
    n_total++; if (grant !== 3'b001) $display("FAIL rst_second_edge_grant: got %b expected 001", grant); else n_pass++;
    clear_masters();
    cycle();
    cycle();
  endtask

  task automatic test_single_write();
    apply_reset();
    m_adr[0] = 27'h100; m_dat_w[0] = 32'hDEADBEEF; m_sel[0] = 4'hF;
    m_we[0] = 1'b1; m_cti[0] = CTI_CLASSIC; m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    #1;
    n_total++; if (grant !== 3'b000) $display("FAIL sw_grant_before: got %b expected 000", grant); else n_pass++;
    cycle();
    n_total++; if (grant !== 3'b001) $display("FAIL sw_grant: got %b expected 001", grant); else n_pass++;
    n_total++; if (s_cyc !== 1'b1 || s_stb !== 1'b1 || s_we !== 1'b1) $display("FAIL sw_s_ctrl: got cyc=%b stb=%b we=%b expected 1 1 1", s_cyc, s_stb, s_we); else n_pass++;
    n_total++; if (s_adr !== 27'h100) $display("FAIL sw_s_adr: got %h expected 100", s_adr); else n_pass++;
    n_total++; if (s_dat_w !== 32'hDEADBEEF) $display("FAIL sw_s_dat: got %h expected deadbeef", s_dat_w); else n_pass++;
    n_total++; if (s_sel !== 4'hF) $display("FAIL sw_s_sel: got %h expected f", s_sel); else n_pass++;
    n_total++; if (m_ack !== 3'b000) $display("FAIL sw_no_early_ack: got %b expected 000", m_ack); else n_pass++;
    cycle();
    n_total++; if (m_ack !== 3'b000) $display("FAIL sw_wait_ack: got %b expected 000", m_ack); else n_pass++;
    cycle();
    ack_force = 1'b1;
    #1;
    n_total++; if (m_ack !== 3'b001) $display("FAIL sw_ack_only_m0: got %b expected 001", m_ack); else n_pass++;
    n_total++; if (m_dat_r[0] !== 32'h12345678) $display("FAIL sw_rdata_m0: got %h expected 12345678", m_dat_r[0]); else n_pass++;
    n_total++; if (m_dat_r[1] !== 32'h0 || m_dat_r[2] !== 32'h0) $display("FAIL sw_rdata_others: got %h %h expected 0 0", m_dat_r[1], m_dat_r[2]); else n_pass++;
    cycle();
    ack_force = 1'b0;
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    #1;
    n_total++; if (m_ack !== 3'b000 || s_cyc !== 1'b0) $display("FAIL sw_release: got ack=%b cyc=%b expected 000 0", m_ack, s_cyc); else n_pass++;
    cycle();
    n_total++; if (grant !== 3'b000) $display("FAIL sw_idle_after: got %b expected 000", grant); else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_tab [9];
    logic [2:0] acked;
    logic [2:0] dropped;
    exp_tab = '{3'b001, 3'b001, 3'b000, 3'b010, 3'b010, 3'b000, 3'b100, 3'b100, 3'b000};
    apply_reset();
    auto_ack = 1'b1;
    for (int i = 0; i < NM; i++) begin
      m_adr[i] = AW'(32'h200 + i * 16);
      m_cyc[i] = 1'b1;
      m_stb[i] = 1'b1;
    end
    acked = '0;
    dropped = '0;
    for (int c = 0; c < 18; c++) begin
      cycle();
      for (int i = 0; i < NM; i++) begin
        if (dropped[i]) begin
          m_cyc[i] = 1'b1; m_stb[i] = 1'b1; dropped[i] = 1'b0;
        end else if (acked[i]) begin
          m_cyc[i] = 1'b0; m_stb[i] = 1'b0; dropped[i] = 1'b1;
        end
      end
      #1;
      acked = m_ack;
      n_total++; if (grant !== exp_tab[c % 9]) $display("FAIL rr_grant_c%0d: got %b expected %b", c + 1, grant, exp_tab[c % 9]); else n_pass++;
    end
    clear_masters();
    auto_ack = 1'b0;
    cycle();
    cycle();
  endtask

  task automatic test_burst_no_split();
    logic [2:0] cti_tab [4];
    cti_tab = '{CTI_INCR, CTI_INCR, CTI_INCR, CTI_EOB};
    apply_reset();
    auto_ack = 1'b1;
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_cti[1] = CTI_INCR; m_adr[1] = 27'h400;
    cycle();
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_adr[0] = 27'h80;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_total++; if (grant !== 3'b010) $display("FAIL burst_grant_beat%0d: got %b expected 010", k, grant); else n_pass++;
      n_total++; if (s_cti !== cti_tab[k]) $display("FAIL burst_cti_beat%0d: got %b expected %b", k, s_cti, cti_tab[k]); else n_pass++;
      n_total++; if (s_adr !== AW'(32'h400 + 4 * k)) $display("FAIL burst_adr_beat%0d: got %h expected %h", k, s_adr, AW'(32'h400 + 4 * k)); else n_pass++;
      n_total++; if (m_ack !== 3'b010) $display("FAIL burst_ack_beat%0d: got %b expected 010", k, m_ack); else n_pass++;
      cycle();
      if (k < 3) begin
        m_cti[1] = cti_tab[k+1];
        m_adr[1] = AW'(32'h400 + 4 * (k + 1));
      end else begin
        m_cyc[1] = 1'b0; m_stb[1] = 1'b0; m_cti[1] = CTI_CLASSIC;
      end
    end
    #1;
    n_total++; if (grant !== 3'b010 || m_ack !== 3'b000) $display("FAIL burst_drop_cycle: got grant=%b ack=%b expected 010 000", grant, m_ack); else n_pass++;
    cycle();
    n_total++; if (grant !== 3'b000) $display("FAIL burst_idle_gap: got %b expected 000", grant); else n_pass++;
    cycle();
    n_total++; if (grant !== 3'b001 || m_ack !== 3'b001) $display("FAIL burst_m0_after: got grant=%b ack=%b expected 001 001", grant, m_ack); else n_pass++;
    clear_masters();
    auto_ack = 1'b0;
    cycle();
    cycle();
  endtask

  task automatic test_timeout_abort();
    apply_reset();
    m_adr[0] = 27'h300; m_we[0] = 1'b1; m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      cycle();
      n_total++; if (m_err !== 3'b000 || s_cyc !== 1'b1) $display("FAIL tmo_stall_c%0d: got err=%b cyc=%b expected 000 1", k, m_err, s_cyc); else n_pass++;
    end
    cycle();
    n_total++; if (m_err !== 3'b001) $display("FAIL tmo_err_c5: got %b expected 001", m_err); else n_pass++;
    n_total++; if (s_cyc !== 1'b0 || s_stb !== 1'b0) $display("FAIL tmo_s_cyc_c5: got %b%b expected 00", s_cyc, s_stb); else n_pass++;
    n_total++; if (m_ack !== 3'b000) $display("FAIL tmo_no_ack_c5: got %b expected 000", m_ack); else n_pass++;
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    cycle();
    n_total++; if (m_err !== 3'b000) $display("FAIL tmo_err_one_cycle: got %b expected 000", m_err); else n_pass++;
    n_total++; if (timeout_cnt !== 16'd1) $display("FAIL tmo_count: got %0d expected 1", timeout_cnt); else n_pass++;
    n_total++; if (grant !== 3'b000) $display("FAIL tmo_idle_after: got %b expected 000", grant); else n_pass++;
  endtask

  task automatic test_ack_at_limit();
    apply_reset();
    m_adr[0] = 27'h310; m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    cycle();
    cycle();
    cycle();
    cycle();
    ack_force = 1'b1;
    #1;
    n_total++; if (m_ack !== 3'b001) $display("FAIL lim_ack_delivered: got %b expected 001", m_ack); else n_pass++;
    n_total++; if (m_err !== 3'b000) $display("FAIL lim_no_err_c4: got %b expected 000", m_err); else n_pass++;
    cycle();
    ack_force = 1'b0;
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    #1;
    n_total++; if (m_err !== 3'b000) $display("FAIL lim_no_err_c5: got %b expected 000", m_err); else n_pass++;
    cycle();
    n_total++; if (timeout_cnt !== 16'd0) $display("FAIL lim_timeout_cnt: got %0d expected 0", timeout_cnt); else n_pass++;
    n_total++; if (grant !== 3'b000) $display("FAIL lim_idle_after: got %b expected 000", grant); else n_pass++;
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    auto_ack = 1'b1;
    m_cyc[2] = 1'b1; m_stb[2] = 1'b1; m_cti[2] = CTI_INCR; m_adr[2] = 27'h600;
    cycle();
    n_total++; if (grant !== 3'b100 || s_cyc !== 1'b1) $display("FAIL mrst_burst_active: got grant=%b cyc=%b expected 100 1", grant, s_cyc); else n_pass++;
    cycle();
    m_adr[2] = 27'h604;
    #2;
    rst_sys_n = 1'b0;
    #1;
    n_total++; if (s_cyc !== 1'b0) $display("FAIL mrst_s_cyc_async: got %b expected 0", s_cyc); else n_pass++;
    n_total++; if (grant !== 3'b000) $display("FAIL mrst_grant_async: got %b expected 000", grant); else n_pass++;
    n_total++; if ((m_ack | m_err | m_rty) !== 3'b000) $display("FAIL mrst_no_response: got %b expected 000", m_ack | m_err | m_rty); else n_pass++;
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_adr[0] = 27'h10;
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_adr[1] = 27'h20;
    cycle();
    cycle();
    rst_sys_n = 1'b1;
    cycle();
    n_total++; if (grant !== 3'b000) $display("FAIL mrst_first_edge: got %b expected 000", grant); else n_pass++;
    cycle();
    n_total++; if (grant !== 3'b001) $display("FAIL mrst_m0_first: got %b expected 001", grant); else n_pass++;
    clear_masters();
    auto_ack = 1'b0;
    cycle();
    cycle();
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    rst_sys_n = 1'b0;
    auto_ack = 1'b0;
    ack_force = 1'b0;
    s_err = 1'b0;
    s_rty = 1'b0;
    s_dat_r = 32'h12345678;
    clear_masters();
    test_reset();
    test_single_write();
    test_round_robin();
    test_burst_no_split();
    test_timeout_abort();
    test_ack_at_limit();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/wb_ext_mem_arbiter.md
WB_EXT_MEM_ARBITER -- requirements
Module: wb_ext_mem_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_MASTERS, default 3, meaning the number of Wishbone masters sharing the external memory port (range 2..8).
REQ-002 The block SHALL have parameter MEM_ADDR_WIDTH, default 27, meaning the address width of masters and slave.
REQ-003 The block SHALL have parameter DATA_WIDTH, default 32, meaning the data width; select width is DATA_WIDTH/8.
REQ-004 The block SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the stalled-strobe cycles before abort (range 1..65535).
REQ-005 The block SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst_sys_n, input, 1, meaning the reset, which is asynchronous and active-low.
REQ-007 The block SHALL have ports m_adr_i/m_dat_i/m_sel_i/m_we_i/m_cyc_i/m_stb_i/m_cti_i/m_bte_i, inputs, NUM_MASTERS x field width, meaning the flattened master requests.
REQ-008 The block SHALL have ports m_dat_o/m_ack_o/m_err_o/m_rty_o, outputs, NUM_MASTERS x field width, meaning the per-master responses.
REQ-009 The block SHALL have ports s_adr_o/s_dat_o/s_sel_o/s_we_o/s_cyc_o/s_stb_o/s_cti_o/s_bte_o, outputs, and s_dat_i/s_ack_i/s_err_i/s_rty_i, inputs, meaning the single external-memory slave port.
REQ-010 The block SHALL have port grant_o, output, NUM_MASTERS, meaning the one-hot current owner (0 when idle).
REQ-011 The block SHALL have port timeout_cnt_o, output, 16, meaning the saturating count of timeout aborts.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, ACTIVE and ABORT.
REQ-013 A master SHALL be requesting only when its m_cyc_i and m_stb_i are both 1.
REQ-014 In IDLE with any request, the FSM SHALL grant round-robin, searching from last_grant+1 upward with wrap to 0, and enter ACTIVE next cycle; arbitration latency SHALL be 1 cycle.
REQ-015 In IDLE, s_cyc_o and s_stb_o SHALL be 0, and all m_ack_o, m_err_o and m_rty_o SHALL be 0.
REQ-016 In ACTIVE, all s_* outputs SHALL combinationally equal the granted master's fields.
REQ-017 In ACTIVE, s_ack_i, s_err_i, s_rty_i and s_dat_i SHALL route only to the granted master; non-granted masters SHALL see 0.
REQ-018 The grant SHALL be held while the granted m_cyc_i=1, so bursts (any cti) are never split.
REQ-019 When the granted m_cyc_i=0 in ACTIVE, the FSM SHALL return to IDLE; this leaves one dead cycle before the next grant.
REQ-020 The 16-bit stall counter SHALL clear on grant and on any s_ack_i, s_err_i or s_rty_i, and SHALL increment in ACTIVE while s_stb_o=1 with no response.
REQ-021 When the stall counter equals TIMEOUT_CYCLES, the FSM SHALL enter ABORT.
REQ-022 In ABORT, the FSM SHALL drive s_cyc_o=s_stb_o=0 and m_err_o[grant]=1 for exactly one cycle, and SHALL increment timeout_cnt_o, saturating at 0xFFFF.
REQ-023 From ABORT, the FSM SHALL go to ACTIVE if the granted m_cyc_i=1, else to IDLE; in either case the stall counter SHALL clear.
REQ-024 If a response arrives in the same cycle the counter reaches TIMEOUT_CYCLES, the response SHALL win and no abort SHALL occur.
REQ-025 last_grant SHALL update only on grant; a single persistent requester SHALL be re-granted.
REQ-026 Simultaneous m_cyc_i drop and s_ack_i SHALL deliver the ack and then enter IDLE.

Reset
REQ-027 While rst_sys_n=0, the FSM SHALL be IDLE, all outputs 0, grant_o=0, counters 0 and last_grant=NUM_MASTERS-1, so master 0 wins first.
REQ-028 Reset assertion mid-transfer SHALL drop s_cyc_o immediately, asynchronously, with no response issued.
REQ-029 Deassertion SHALL be synchronised externally, and the first grant SHALL occur no earlier than the second clk edge after deassertion.

Structure
REQ-030 Package wb_arb_pkg SHALL hold the FSM state enum, CTI constants (CLASSIC=3'b000, INCR=3'b010, EOB=3'b111) and the timeout counter width.
REQ-031 Round-robin selection SHALL be a sub-module, rr_arbiter (request vector plus last_grant in, one-hot grant out, combinational).
REQ-032 A wb_intercon-generated instance SHALL be able to drive the slave port directly.

Verification
REQ-033 The bench SHALL drive master 0 single write adr=0x100, dat=0xDEADBEEF, with the slave acking after 2 cycles, and SHALL check grant_o=001 one cycle after request, the write seen at the slave, and m_ack_o[0] only.
REQ-034 The bench SHALL drive masters 0, 1 and 2 requesting continuously with single-cycle acks, and SHALL check the grant order 0,1,2,0,1,2 with one IDLE cycle between each.
REQ-035 The bench SHALL drive master 1 with a 4-beat INCR burst (cti 010,010,010,111) while master 0 requests, and SHALL check that master 0 gets no grant until master 1 drops m_cyc_i.
REQ-036 The bench SHALL run with TIMEOUT_CYCLES=4 and a slave that never acks, and SHALL check m_err_o=1 on the 5th cycle after the strobe for one cycle, s_cyc_o=0 that cycle, and timeout_cnt_o=1.
REQ-037 The bench SHALL run with TIMEOUT_CYCLES=4 and an ack in the 4th stall cycle, and SHALL check the ack is delivered, m_err_o stays 0 and timeout_cnt_o stays 0.
REQ-038 The bench SHALL assert rst_sys_n=0 mid-burst, and SHALL check s_cyc_o=0 and grant_o=0 within the same cycle, and master 0 granted first after release.
